// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: valid/ready input FIFO feeding an LSB-first serialiser.
// Baud divisor, parity and stop-bit count are latched per frame when a word is popped.
module uart_tx_fifo #(
  parameter int unsigned PAYLOAD_BITS = 8,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned DIV_W        = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [PAYLOAD_BITS-1:0]       s_data,
  input  logic [DIV_W-1:0]              cfg_divisor,
  input  logic [1:0]                    cfg_parity,
  input  logic                          cfg_stop2,
  output logic                          uart_txd,
  output logic                          busy,
  output logic                          frame_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned BW = $clog2(PAYLOAD_BITS);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e                  r_state, w_state_d;
  logic [PAYLOAD_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]           r_wptr, r_rptr;
  logic [LW-1:0]           r_level;
  logic [PAYLOAD_BITS-1:0] r_shift;
  logic [DIV_W-1:0]        r_div, r_cnt;
  logic                    r_par_en, r_par_bit, r_stop2, r_stop_idx;
  logic [BW-1:0]           r_bit_idx;
  logic                    r_txd, r_frame_done;

  logic                    w_push, w_pop, w_tick, w_last_data, w_frame_end, w_nonempty, w_txd_d;
  logic [PAYLOAD_BITS-1:0] w_head;

  assign s_ready     = (r_level != LW'(FIFO_DEPTH));
  assign w_push      = s_valid & s_ready;
  assign w_nonempty  = (r_level != '0);
  assign w_head      = r_mem[r_rptr];
  assign w_tick      = (r_cnt == r_div);
  assign w_last_data = (r_bit_idx == BW'(PAYLOAD_BITS - 1));
  assign w_frame_end = (r_state == StStop) & w_tick & (r_stop_idx == r_stop2);

  assign uart_txd   = r_txd;
  assign busy       = (r_state != StIdle);
  assign frame_done = r_frame_done;
  assign fifo_level = r_level;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= StIdle;
    else       r_state <= w_state_d;
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:   if (w_nonempty) w_state_d = StStart;
      StStart:  if (w_tick) w_state_d = StData;
      StData:   if (w_tick && w_last_data) w_state_d = r_par_en ? StParity : StStop;
      StParity: if (w_tick) w_state_d = StStop;
      StStop:   if (w_frame_end) w_state_d = w_nonempty ? StStart : StIdle;
      default:  w_state_d = StIdle;
    endcase
  end

  // Line value is registered from the current state, so txd trails the FSM by one clock.
  always_comb begin
    w_txd_d = 1'b1;
    w_pop   = 1'b0;
    unique case (r_state)
      StIdle:   w_pop = w_nonempty;
      StStart:  w_txd_d = 1'b0;
      StData:   w_txd_d = r_shift[0];
      StParity: w_txd_d = r_par_bit;
      StStop:   w_pop = w_frame_end & w_nonempty;
      default:  w_txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= s_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shift    <= '0;
      r_div      <= '0;
      r_cnt      <= '0;
      r_par_en   <= 1'b0;
      r_par_bit  <= 1'b0;
      r_stop2    <= 1'b0;
      r_stop_idx <= 1'b0;
      r_bit_idx  <= '0;
    end else if (w_pop) begin
      r_shift    <= w_head;
      r_div      <= cfg_divisor;
      r_cnt      <= '0;
      r_par_en   <= (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
      r_par_bit  <= (^w_head) ^ (cfg_parity == 2'b10);
      r_stop2    <= cfg_stop2;
      r_stop_idx <= 1'b0;
      r_bit_idx  <= '0;
    end else if (r_state != StIdle) begin
      if (w_tick) begin
        r_cnt <= '0;
        if (r_state == StData) begin
          r_shift   <= {1'b0, r_shift[PAYLOAD_BITS-1:1]};
          r_bit_idx <= r_bit_idx + 1'b1;
        end
        if (r_state == StStop) r_stop_idx <= 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_txd        <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      r_txd        <= w_txd_d;
      r_frame_done <= w_frame_end;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: an 8-bit depth-4 instance and a 5-bit instance.
// Expected line waveforms are built from the frame format, clock by clock.
module tb_uart_tx_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic        s_valid8, s_ready8, s_valid5, s_ready5;
  logic [7:0]  s_data8;
  logic [4:0]  s_data5;
  logic [15:0] cfg_divisor;
  logic [1:0]  cfg_parity;
  logic        cfg_stop2;
  logic        txd8, busy8, done8, txd5, busy5, done5;
  logic [2:0]  level8, level5;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  uart_tx_fifo #(.PAYLOAD_BITS(8), .FIFO_DEPTH(4), .DIV_W(16)) u_dut8 (
    .clk(clk), .reset(reset), .s_valid(s_valid8), .s_ready(s_ready8), .s_data(s_data8),
    .cfg_divisor(cfg_divisor), .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2),
    .uart_txd(txd8), .busy(busy8), .frame_done(done8), .fifo_level(level8)
  );

  uart_tx_fifo #(.PAYLOAD_BITS(5), .FIFO_DEPTH(4), .DIV_W(16)) u_dut5 (
    .clk(clk), .reset(reset), .s_valid(s_valid5), .s_ready(s_ready5), .s_data(s_data5),
    .cfg_divisor(cfg_divisor), .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2),
    .uart_txd(txd5), .busy(busy5), .frame_done(done5), .fifo_level(level5)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks every clock of one frame, starting at the first start-bit sample.
  task automatic check_frame(input string tag, input bit sel, input logic [8:0] data,
                             input int nb, input int div, input logic [1:0] par,
                             input bit stop2);
    logic bits [13];
    logic x;
    int   n;
    n = 0;
    x = 1'b0;
    bits[n] = 1'b0; n++;
    for (int i = 0; i < nb; i++) begin
      bits[n] = data[i]; n++;
      x = x ^ data[i];
    end
    if (par == 2'b01) begin bits[n] = x;  n++; end
    if (par == 2'b10) begin bits[n] = ~x; n++; end
    bits[n] = 1'b1; n++;
    if (stop2) begin bits[n] = 1'b1; n++; end
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c <= div; c++) begin
        chk({tag, "_txd"}, sel ? txd5 : txd8, bits[i]);
        chk({tag, "_done"}, sel ? done5 : done8, (i == n - 1) && (c == div));
        tick(1);
      end
    end
  endtask

  task automatic send_idle(input string tag, input logic [7:0] data, input logic [1:0] par,
                           input bit stop2);
    s_valid8   = 1'b1;
    s_data8    = data;
    cfg_parity = par;
    cfg_stop2  = stop2;
    tick(1);
    s_valid8 = 1'b0;
    chk({tag, "_lvl_acc"}, level8, 1);
    chk({tag, "_txd_acc"}, txd8, 1);
    tick(1);
    chk({tag, "_busy_pop"}, busy8, 1);
    chk({tag, "_lvl_pop"}, level8, 0);
    chk({tag, "_txd_pop"}, txd8, 1);
    tick(1);
    check_frame(tag, 1'b0, {1'b0, data}, 8, int'(cfg_divisor), par, stop2);
    chk({tag, "_busy_end"}, busy8, 0);
    chk({tag, "_txd_end"}, txd8, 1);
  endtask

  initial begin
    logic [7:0] words [6];
    reset       = 1'b1;
    s_valid8    = 1'b0;
    s_valid5    = 1'b0;
    s_data8     = '0;
    s_data5     = '0;
    cfg_divisor = 16'd3;
    cfg_parity  = 2'b00;
    cfg_stop2   = 1'b0;
    #2;
    chk("rst_txd", txd8, 1);
    chk("rst_ready", s_ready8, 1);
    chk("rst_busy", busy8, 0);
    chk("rst_done", done8, 0);
    chk("rst_level", level8, 0);
    tick(1);
    reset = 1'b0;
    tick(1);

    send_idle("a5", 8'hA5, 2'b00, 1'b0);
    send_idle("even07", 8'h07, 2'b01, 1'b0);
    send_idle("odd07s2", 8'h07, 2'b10, 1'b1);

    // FIFO fill with depth 4: six words held on the input, streamed back to back.
    cfg_divisor = 16'd1;
    cfg_parity  = 2'b00;
    cfg_stop2   = 1'b0;
    words[0] = 8'h01; words[1] = 8'h80; words[2] = 8'hFF;
    words[3] = 8'h00; words[4] = 8'h3C; words[5] = 8'hC3;
    fork
      begin : producer
        int  idx;
        int  cycles;
        bit  seen;
        logic rdy;
        idx = 0; cycles = 0; seen = 1'b0;
        s_valid8 = 1'b1;
        s_data8  = words[0];
        while (idx < 6 && cycles < 300) begin
          rdy = s_ready8;
          tick(1);
          cycles++;
          if (rdy) begin
            idx++;
            if (idx < 6) s_data8 = words[idx];
            else         s_valid8 = 1'b0;
          end
          if (cycles == 5) begin
            chk("fill_idx", idx, 5);
            chk("fill_level", level8, 4);
            chk("fill_ready", s_ready8, 0);
          end
          if (!seen && idx == 5 && cycles > 5 && s_ready8) begin
            seen = 1'b1;
            chk("fill_ready_at_done", done8, 1);
          end
        end
        s_valid8 = 1'b0;
        chk("fill_all_accepted", idx, 6);
      end
      begin : consumer
        int n;
        n = 0;
        while (txd8 !== 1'b0 && n < 50) begin
          tick(1);
          n++;
        end
        chk("fill_start_seen", txd8, 0);
        for (int k = 0; k < 6; k++) check_frame("fill", 1'b0, {1'b0, words[k]}, 8, 1, 2'b00, 1'b0);
      end
    join
    chk("fill_busy_end", busy8, 0);
    chk("fill_level_end", level8, 0);

    // Divisor change while the first frame is in flight applies to the second only.
    cfg_divisor = 16'd3;
    s_valid8 = 1'b1;
    s_data8  = 8'h5A;
    tick(1);
    s_data8 = 8'h96;
    tick(1);
    s_valid8    = 1'b0;
    cfg_divisor = 16'd7;
    tick(1);
    check_frame("div3", 1'b0, 9'h05A, 8, 3, 2'b00, 1'b0);
    check_frame("div7", 1'b0, 9'h096, 8, 7, 2'b00, 1'b0);
    chk("div_busy_end", busy8, 0);

    // Reset during data bit 3 with two words still queued.
    cfg_divisor = 16'd3;
    s_valid8 = 1'b1;
    s_data8  = 8'hF0;
    tick(1);
    s_data8 = 8'h11;
    tick(1);
    s_data8 = 8'h22;
    tick(1);
    s_valid8 = 1'b0;
    chk("mid_level", level8, 2);
    tick(17);
    chk("mid_bit3", txd8, 0);
    chk("mid_busy", busy8, 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_txd", txd8, 1);
    chk("mid_rst_busy", busy8, 0);
    chk("mid_rst_level", level8, 0);
    chk("mid_rst_ready", s_ready8, 1);
    chk("mid_rst_done", done8, 0);
    tick(1);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("post_rst_txd", txd8, 1);
      chk("post_rst_busy", busy8, 0);
      chk("post_rst_done", done8, 0);
    end

    // 5-bit payload, one clock per bit, reserved parity code sends no parity bit.
    cfg_divisor = 16'd0;
    cfg_parity  = 2'b11;
    cfg_stop2   = 1'b0;
    s_valid5 = 1'b1;
    s_data5  = 5'h16;
    tick(1);
    s_valid5 = 1'b0;
    chk("p5_level", level5, 1);
    tick(1);
    chk("p5_busy", busy5, 1);
    chk("p5_txd_pop", txd5, 1);
    tick(1);
    check_frame("p5", 1'b1, 9'h016, 5, 0, 2'b11, 1'b0);
    chk("p5_busy_end", busy5, 0);
    chk("p5_txd_end", txd5, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
